// File: rtl/keypad_scan_decoder_if.sv
// keypad_scan_decoder_if: pins and consumer-side signals of the player B keypad decoder.
// master: the decoder (drives columns and the decoded key outputs).
// slave : the keypad pins plus the consumer (drives rows, observes the rest).
interface keypad_scan_decoder_if;
    logic [3:0] Row;
    logic [3:0] Col;
    logic [3:0] playerB;
    logic       key_valid;
    logic       key_press;

    modport master (
        input  Row,
        output Col,
        output playerB,
        output key_valid,
        output key_press
    );

    modport slave (
        output Row,
        input  Col,
        input  playerB,
        input  key_valid,
        input  key_press
    );
endinterface

// File: rtl/keypad_scan_decoder.sv
// keypad_scan_decoder: scans the 4x4 Pmod keypad for player B, debounces whole
// scan results and presents the held key as a registered 4-bit code.
// Optional build macro: KYPD_REPEAT_EN adds an auto-repeat timer on key_press.
//
// state | meaning
// ------+----------------------------------------------------------
// COL0  | Col=0111 driven; rows sampled in the last settle cycle
// COL1  | Col=1011 driven; rows sampled in the last settle cycle
// COL2  | Col=1101 driven; rows sampled in the last settle cycle
// COL3  | Col=1110 driven; last sample closes the scan and debounces
module keypad_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_CYCLES  = 25000000
) (
    input  logic                  clk,
    input  logic                  rst,
    keypad_scan_decoder_if.master kp
);

    // Reject parameter values the counters below cannot represent.
    generate
        if (SETTLE_CYCLES < 3 || DEBOUNCE_SCANS < 1 || REPEAT_CYCLES < 1) begin : g_param_check
            $error("keypad_scan_decoder: illegal parameter value");
        end
    endgenerate

    localparam int unsigned      SW          = $clog2(SETTLE_CYCLES);
    localparam int unsigned      DW          = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0]    SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0]    MATCH_MAX   = DW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } state_e;

    // Physical key legend: column index, then row index (row 0 = Row[3]).
    function automatic logic [3:0] key_code(input logic [1:0] col, input logic [1:0] row);
        logic [3:0] code;
        case ({col, row})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h4;
            4'h2:    code = 4'h7;
            4'h3:    code = 4'h0;
            4'h4:    code = 4'h2;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h8;
            4'h7:    code = 4'hF;
            4'h8:    code = 4'h3;
            4'h9:    code = 4'h6;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hE;
            4'hC:    code = 4'hA;
            4'hD:    code = 4'hB;
            4'hE:    code = 4'hC;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    state_e          state_q, state_d;
    logic [3:0]      col_q, col_d;
    logic [3:0]      row_meta_q, row_sync_q;
    logic [SW-1:0]   settle_q, settle_d;
    logic            settle_done;

    logic            row_hit;
    logic [1:0]      row_idx;
    logic [1:0]      col_idx;
    logic [3:0]      col_code;
    logic            scan_hit;
    logic [3:0]      scan_code;

    logic            hit_q, hit_d;
    logic [3:0]      code_q, code_d;

    logic            scan_end;
    logic            same_result;
    logic [DW-1:0]   match_next;
    logic            accept;
    logic            prev_hit_q, prev_hit_d;
    logic [3:0]      prev_code_q, prev_code_d;
    logic [DW-1:0]   match_q, match_d;

    logic [3:0]      player_q, player_d;
    logic            valid_q, valid_d;
    logic            press_q, press_d;
    logic            rpt_fire;

    // Two-flop synchronizer for the asynchronous row returns; idles at "no row pulled low".
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= kp.Row;
            row_sync_q <= row_meta_q;
        end
    end

    // Settle timer: counts down the cycles a column is driven, terminal count marks the sample cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q <= SETTLE_LOAD;
        end else begin
            settle_q <= settle_d;
        end
    end

    // Settle timer reload on terminal count.
    always_comb begin
        settle_done = (settle_q == '0);
        settle_d    = settle_done ? SETTLE_LOAD : settle_q - 1'b1;
    end

    // FSM state register; the column drive is registered alongside it so Col never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COL0;
            col_q   <= 4'b0111;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
        end
    end

    // FSM next state: advance one column per settle period, wrapping after COL3.
    always_comb begin
        state_d = state_q;
        if (settle_done) begin
            case (state_q)
                COL0:    state_d = COL1;
                COL1:    state_d = COL2;
                COL2:    state_d = COL3;
                default: state_d = COL0;
            endcase
        end
    end

    // FSM output: one-hot-low column drive for the state being entered.
    always_comb begin
        case (state_d)
            COL0:    col_d = 4'b0111;
            COL1:    col_d = 4'b1011;
            COL2:    col_d = 4'b1101;
            default: col_d = 4'b1110;
        endcase
    end

    assign col_idx = state_q;

    // Lowest-numbered pulled-low row of the synchronized returns wins within a column.
    always_comb begin
        row_hit = 1'b1;
        row_idx = 2'd0;
        if (!row_sync_q[3]) begin
            row_idx = 2'd0;
        end else if (!row_sync_q[2]) begin
            row_idx = 2'd1;
        end else if (!row_sync_q[1]) begin
            row_idx = 2'd2;
        end else if (!row_sync_q[0]) begin
            row_idx = 2'd3;
        end else begin
            row_hit = 1'b0;
        end
    end

    // Scan result so far: an earlier column's hit keeps priority over the current column.
    always_comb begin
        col_code = key_code(col_idx, row_idx);
        if (hit_q) begin
            scan_hit  = 1'b1;
            scan_code = code_q;
        end else if (row_hit) begin
            scan_hit  = 1'b1;
            scan_code = col_code;
        end else begin
            scan_hit  = 1'b0;
            scan_code = 4'h0;
        end
    end

    // Partial-scan accumulator update: capture at each sample, restart when the scan closes.
    always_comb begin
        hit_d  = hit_q;
        code_d = code_q;
        if (settle_done) begin
            if (state_q == COL3) begin
                hit_d  = 1'b0;
                code_d = 4'h0;
            end else begin
                hit_d  = scan_hit;
                code_d = scan_code;
            end
        end
    end

    // Partial-scan accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q  <= 1'b0;
            code_q <= 4'h0;
        end else begin
            hit_q  <= hit_d;
            code_q <= code_d;
        end
    end

    // Debounce: count consecutive identical scan results and decide acceptance at scan end.
    always_comb begin
        scan_end    = settle_done && (state_q == COL3);
        same_result = (scan_hit == prev_hit_q) && (scan_code == prev_code_q);
        if (!same_result) begin
            match_next = DW'(1);
        end else if (match_q == MATCH_MAX) begin
            match_next = match_q;
        end else begin
            match_next = match_q + 1'b1;
        end
        accept = scan_end && (match_next == MATCH_MAX) &&
                 ((scan_hit != valid_q) || (scan_code != player_q));
        prev_hit_d  = prev_hit_q;
        prev_code_d = prev_code_q;
        match_d     = match_q;
        if (scan_end) begin
            prev_hit_d  = scan_hit;
            prev_code_d = scan_code;
            match_d     = match_next;
        end
    end

    // Debounce history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_hit_q  <= 1'b0;
            prev_code_q <= 4'h0;
            match_q     <= '0;
        end else begin
            prev_hit_q  <= prev_hit_d;
            prev_code_q <= prev_code_d;
            match_q     <= match_d;
        end
    end

`ifdef KYPD_REPEAT_EN
    localparam int unsigned   RW       = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] RPT_LOAD = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rpt_q, rpt_d;

    // Repeat timer: restarts on every accepted change, re-fires each period while a key stays held.
    always_comb begin
        rpt_d    = rpt_q;
        rpt_fire = 1'b0;
        if (accept) begin
            rpt_d = RPT_LOAD;
        end else if (valid_q) begin
            if (rpt_q == '0) begin
                rpt_fire = 1'b1;
                rpt_d    = RPT_LOAD;
            end else begin
                rpt_d = rpt_q - 1'b1;
            end
        end
    end

    // Repeat timer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rpt_q <= '0;
        end else begin
            rpt_q <= rpt_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // Stable key outputs follow an accepted result; release is accepted but never strobes.
    always_comb begin
        player_d = player_q;
        valid_d  = valid_q;
        if (accept) begin
            player_d = scan_code;
            valid_d  = scan_hit;
        end
        press_d = (accept && scan_hit) || rpt_fire;
    end

    // Registered outputs toward chara_control.
    always_ff @(posedge clk) begin
        if (rst) begin
            player_q <= 4'h0;
            valid_q  <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            player_q <= player_d;
            valid_q  <= valid_d;
            press_q  <= press_d;
        end
    end

    assign kp.Col       = col_q;
    assign kp.playerB   = player_q;
    assign kp.key_valid = valid_q;
    assign kp.key_press = press_q;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// tb_keypad_scan_decoder: keypad pin model plus a scan-level reference model.
// Key changes are applied at scan boundaries; the model predicts every cycle's outputs.
module tb_keypad_scan_decoder;

    localparam int SETTLE = 4;
    localparam int DEB    = 2;
    localparam int REP    = 40;
    localparam int NONE   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] held = 16'h0000;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int t;
    int prev_res;
    int match_cnt;
    int stable;
    int exp_pb;
    int exp_v;
    int exp_press;
    int last_pulse;

    // key legend indexed by position col*4+row
    int key_map [16] = '{1, 4, 7, 0, 2, 5, 8, 15, 3, 6, 9, 14, 10, 11, 12, 13};

    always #5 clk = ~clk;

    keypad_scan_decoder_if kif ();

    keypad_scan_decoder #(
        .SETTLE_CYCLES (SETTLE),
        .DEBOUNCE_SCANS(DEB),
        .REPEAT_CYCLES (REP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kp (kif)
    );

    // Keypad pins: a held key pulls its row low while its column is driven low.
    function automatic logic [3:0] pad_rows(input logic [3:0] col, input logic [15:0] keys);
        logic [3:0] r;
        r = 4'hF;
        for (int j = 0; j < 4; j++) begin
            if (col[3-j] == 1'b0) begin
                for (int i = 0; i < 4; i++) begin
                    if (keys[j*4+i]) r[3-i] = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign kif.Row = pad_rows(kif.Col, held);

    // First key in scan order (column, then row), or NONE.
    function automatic int scan_result(input logic [15:0] keys);
        for (int p = 0; p < 16; p++) begin
            if (keys[p]) return p;
        end
        return NONE;
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        t          = 0;
        prev_res   = NONE;
        match_cnt  = 0;
        stable     = NONE;
        exp_pb     = 0;
        exp_v      = 0;
        exp_press  = 0;
        last_pulse = 0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_col", kif.Col, 4'b0111);
            chk("rst_playerB", kif.playerB, 4'h0);
            chk("rst_key_valid", {3'b000, kif.key_valid}, 4'h0);
            chk("rst_key_press", {3'b000, kif.key_press}, 4'h0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    // Compare the current cycle, then advance the model and the clock by one cycle.
    task automatic tick();
        logic [3:0] exp_col;
        int         res;
        bit         upd;
        exp_col = 4'hF;
        exp_col[3 - ((t % 16) / 4)] = 1'b0;
        chk("col", kif.Col, exp_col);
        chk("playerB", kif.playerB, 4'(exp_pb));
        chk("key_valid", {3'b000, kif.key_valid}, 4'(exp_v));
        chk("key_press", {3'b000, kif.key_press}, 4'(exp_press));

        upd       = 1'b0;
        exp_press = 0;
        if ((t % 16) == 15) begin
            res = scan_result(held);
            if (res == prev_res) match_cnt = (match_cnt < DEB) ? match_cnt + 1 : DEB;
            else                 match_cnt = 1;
            prev_res = res;
            if (match_cnt == DEB && res != stable) begin
                stable = res;
                upd    = 1'b1;
                exp_v  = (res != NONE) ? 1 : 0;
                exp_pb = (res == NONE) ? 0 : key_map[res];
                if (exp_v == 1) begin
                    exp_press  = 1;
                    last_pulse = t + 1;
                end
            end
        end
`ifdef KYPD_REPEAT_EN
        if (!upd && exp_v == 1 && (t + 1 - last_pulse) == REP) begin
            exp_press  = 1;
            last_pulse = t + 1;
        end
`endif
        @(negedge clk);
        t++;
    endtask

    task automatic run_scans(input logic [15:0] keys, input int n);
        held = keys;
        repeat (n * 16) tick();
    endtask

    initial begin
        logic [15:0] keys;
        int          kind;

        model_reset();
        do_reset(3);

        // idle, then key 5 held three scans, then release
        run_scans(16'h0000, 2);
        run_scans(16'h0001 << 5, 3);
        run_scans(16'h0000, 3);

        // key 8 bouncing on alternate scans never gets accepted
        for (int i = 0; i < 3; i++) begin
            run_scans(16'h0001 << 6, 1);
            run_scans(16'h0000, 1);
        end

        // keys 4 and 2 together: column 0 wins
        run_scans((16'h0001 << 1) | (16'h0001 << 4), 3);
        run_scans(16'h0000, 3);

        // key 6 held long enough to see auto-repeat when it is built in
        run_scans(16'h0001 << 9, 8);
        run_scans(16'h0000, 3);

        // key 0 (valid with code 0), then a direct change to key 5, then release
        run_scans(16'h0001 << 3, 3);
        run_scans(16'h0001 << 5, 3);
        run_scans(16'h0000, 3);

        // reset in the middle of a scan drops the partial result and history
        run_scans(16'h0001 << 5, 1);
        repeat (9) tick();
        do_reset(2);
        run_scans(16'h0001 << 5, 3);
        run_scans(16'h0000, 3);

        // randomized key sets and hold lengths
        for (int r = 0; r < 60; r++) begin
            kind = int'($urandom_range(0, 3));
            if (kind == 0)      keys = 16'h0000;
            else if (kind == 3) keys = 16'($urandom);
            else                keys = 16'h0001 << $urandom_range(0, 15);
            run_scans(keys, int'($urandom_range(1, 4)));
        end
        run_scans(16'h0000, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
